// File: rtl/latch_downcounter_pkg.sv
// latch_downcounter_pkg: shared state encoding, defaults and prescaler width helper
package latch_downcounter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_PRESCALE = 1;
  function automatic int ps_width(input int p);
    return (p <= 2) ? 1 : $clog2(p);
  endfunction
endpackage

// File: rtl/latch_downcounter_tick_prescaler.sv
// tick_prescaler: PRESCALE-cycle divider producing a one-cycle tick while enabled
module tick_prescaler
  import latch_downcounter_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int PW = ps_width(PRESCALE);
  logic [PW-1:0] cnt_q, cnt_d;
  assign tick = en && (cnt_q == PW'(PRESCALE - 1));
  always_comb cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + PW'(1);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/latch_downcounter.sv
// latch_downcounter: loadable prescaled down-counter that latches at zero with done pulse.
// Define LATCH_DOWNCOUNTER_RELOAD_EN to reload the last loaded value at zero (periodic timer).
module latch_downcounter
  import latch_downcounter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             zero,
  output logic             done
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic busy_q, zero_q, done_q, done_d, tick;
`ifdef LATCH_DOWNCOUNTER_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif
  // a load or clear restarts the prescaler phase so the first decrement is a full period away
  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (clear | load),
    .en  (en && state_q == RUN),
    .tick(tick)
  );
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d = 1'b0;
`ifdef LATCH_DOWNCOUNTER_RELOAD_EN
    reload_d = reload_q;
`endif
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
      state_d = (load_value != '0) ? RUN : DONE;
      done_d = (load_value == '0);
`ifdef LATCH_DOWNCOUNTER_RELOAD_EN
      reload_d = load_value;
`endif
    end else if (state_q == RUN && tick) begin
      done_d = (count_q == WIDTH'(1));
`ifdef LATCH_DOWNCOUNTER_RELOAD_EN
      count_d = done_d ? reload_q : count_q - WIDTH'(1);
`else
      count_d = count_q - WIDTH'(1);
      state_d = done_d ? DONE : RUN;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q <= 1'b0;
      zero_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q <= (state_d == RUN);
      zero_q <= (count_d == '0);
      done_q <= done_d;
    end
  end
`ifdef LATCH_DOWNCOUNTER_RELOAD_EN
  always_ff @(posedge clk) reload_q <= rst ? '0 : reload_d;
`endif
  assign count = count_q;
  assign busy = busy_q;
  assign zero = zero_q;
  assign done = done_q;
endmodule

// File: tb/tb_latch_downcounter.sv
// tb_latch_downcounter: directed and random checks of PRESCALE=1 and PRESCALE=4 instances against a cycle-count model
module tb_latch_downcounter;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, load = 1'b0, en = 1'b0;
  logic [7:0] load_value = '0;
  logic [7:0] cnt [2];
  logic busy [2], zero [2], done [2];
  int n_assert = 0, n_fail = 0;
  localparam int PS [2] = '{1, 4};
  bit m_act [2];
  int m_n [2], m_e [2];
  bit m_done [2];

  always #5 clk = ~clk;

  latch_downcounter #(.WIDTH(8), .PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_value(load_value), .en(en),
    .count(cnt[0]), .busy(busy[0]), .zero(zero[0]), .done(done[0]));
  latch_downcounter #(.WIDTH(8), .PRESCALE(4)) u4 (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_value(load_value), .en(en),
    .count(cnt[1]), .busy(busy[1]), .zero(zero[1]), .done(done[1]));

  // model: count follows from the loaded value and the number of enabled running cycles since the load
  function automatic int exp_cnt(input int i);
    int q;
    if (!m_act[i] || m_n[i] == 0) return 0;
    q = m_e[i] / PS[i];
`ifdef LATCH_DOWNCOUNTER_RELOAD_EN
    return m_n[i] - (q % m_n[i]);
`else
    return (q >= m_n[i]) ? 0 : m_n[i] - q;
`endif
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit c, input bit l, input int lv, input bit e);
    rst = r; clear = c; load = l; load_value = lv[7:0]; en = e;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (r || c) begin
        m_act[i] = 1'b0; m_n[i] = 0; m_e[i] = 0;
      end else if (l) begin
        m_act[i] = 1'b1; m_n[i] = lv & 255; m_e[i] = 0;
        m_done[i] = (m_n[i] == 0);
      end else if (e && exp_cnt(i) != 0) begin
        m_e[i]++;
`ifdef LATCH_DOWNCOUNTER_RELOAD_EN
        m_done[i] = (m_e[i] % (m_n[i] * PS[i]) == 0);
`else
        m_done[i] = (m_e[i] == m_n[i] * PS[i]);
`endif
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("count[P%0d]", PS[i]), int'(cnt[i]), exp_cnt(i));
      chk($sformatf("busy[P%0d]", PS[i]), int'(busy[i]), int'(exp_cnt(i) != 0));
      chk($sformatf("zero[P%0d]", PS[i]), int'(zero[i]), int'(exp_cnt(i) == 0));
      chk($sformatf("done[P%0d]", PS[i]), int'(done[i]), int'(m_done[i]));
    end
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 5, 1);
    chk("load5_count", int'(cnt[0]), 5);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1);
`ifndef LATCH_DOWNCOUNTER_RELOAD_EN
    chk("p1_done_at_zero", int'(done[0]), 1);
    chk("p1_count_zero", int'(cnt[0]), 0);
`endif
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 3, 1);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1);
    chk("p4_first_dec", int'(cnt[1]), 2);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 0);
    chk("p4_frozen", int'(cnt[1]), 2);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 1);
    chk("p4_done_after_18", int'(done[1]), 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    chk("load0_done", int'(done[0]), 1);
    chk("load0_busy", int'(busy[0]), 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 2, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 7, 1);
    chk("reload_wins_count", int'(cnt[0]), 7);
    chk("reload_wins_nodone", int'(done[0]), 0);
    step(0, 0, 1, 9, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    chk("clear_count", int'(cnt[0]), 0);
    chk("clear_nodone", int'(done[0]), 0);
    step(0, 0, 1, 3, 1);
    for (int k = 0; k < 9; k++) step(0, 0, 0, 0, 1);
    for (int k = 0; k < 3000; k++) begin
      int lv;
      lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0,
           lv, $urandom_range(0, 3) != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/latch_downcounter.md
# latch_downcounter

Loadable, prescaled down-counter that counts a programmed value toward zero and latches there, raising a one-cycle `done` pulse and a sticky `zero` flag. It is the count-down counterpart of the team's saturating up-counter: where that block climbs to its maximum and holds, this one is loaded with a start value, decrements once per prescaled tick while enabled, and holds at zero until it is reloaded. It is intended for timeouts, debounce windows and display-refresh intervals in the lab designs.

## Interface
Parameters:
- `WIDTH`, 8: bit width of the count and load value.
- `PRESCALE`, 1: clock cycles per decrement; must be ≥1.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `clear`  input  1  abort: return to IDLE with count 0; no `done` pulse.
- `load`  input  1  single-cycle strobe that captures `load_value` and starts counting.
- `load_value`  input  WIDTH  start value sampled when `load`=1.
- `en`  input  1  count enable; when low, count and prescaler freeze.
- `count`  output  WIDTH  current count value.
- `busy`  output  1  high in RUN.
- `zero`  output  1  high whenever `count`==0.
- `done`  output  1  one-cycle pulse on the edge where the count reaches 0.

## Operation
- States: IDLE, RUN, DONE.
- Priority per edge: `rst` > `clear` > `load` > tick.
- Reset: state IDLE, `count`=0, prescaler=0, `busy`=0, `zero`=1, `done`=0.
- `clear` in any state: IDLE, `count`=0, prescaler=0, `done`=0.
- `load` in any state: `count`←`load_value`, prescaler←0. If `load_value`≠0 → RUN, `done`=0. If `load_value`=0 → DONE with `done`=1 for that cycle.
- Prescaler runs only in RUN with `en`=1, counting 0..PRESCALE-1. A tick occurs on the edge where the prescaler equals PRESCALE-1; the prescaler then wraps to 0.
- On a tick in RUN: `count`←`count`-1. If `count` was 1 → DONE and `done`=1 for exactly one cycle.
- DONE: `count` is latched at 0 and `en` is ignored. The block leaves DONE only on `load`, `clear` or `rst`.
- IDLE: `count` holds 0 and `en` is ignored.
- `en`=0 in RUN: `count` and prescaler hold; counting resumes where it stopped.
- Arithmetic: unsigned, WIDTH bits. The count never decrements below 0 and never wraps.
- `zero` and `busy` are registered state decodes and are consistent with `count` every cycle.

## Timing
- `load` sampled at edge k: `count`=`load_value` and `busy`=1 are visible after edge k.
- First decrement occurs at edge k+PRESCALE if `en` is held high.
- Load value N with continuous `en`: `done`=1 after edge k+N·PRESCALE and low again after the following edge.
- `load` coinciding with a tick: the load wins; no decrement and no `done`.
- `load` coinciding with reaching zero: the load wins; no `done` pulse.
- `rst` or `clear` mid-count takes effect at that edge; no `done` pulse.

## Configuration
- `LATCH_DOWNCOUNTER_RELOAD_EN` defined:
  - A WIDTH-bit reload register captures `load_value` on every `load`.
  - On a tick that would reach 0, `count` is set to the reload value, the state stays RUN and `done` still pulses, giving a periodic timer with period N·PRESCALE.
  - DONE is reachable only through a load of 0.
- Macro undefined: latch-at-zero behaviour exactly as in Operation. The reload register is not instantiated.

## Structure
- Shared package holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default WIDTH and PRESCALE values;
  - the prescaler width function, clog2(PRESCALE) with a minimum of 1.
- One sub-module, `tick_prescaler`: a PRESCALE-cycle divider with `clk`, `rst`, synchronous `clr`, `en` and a one-cycle `tick` output. Instantiated once.
- The FSM and the count register live in the top module.

## Test plan
- Reset, then idle for 5 cycles → `count`=0, `zero`=1, `busy`=0, `done`=0 throughout.
- PRESCALE=1, load 5 with `en`=1 → `count` reads 5,4,3,2,1,0 on consecutive cycles; `done` high for exactly 1 cycle with 0; `count` stays 0 for 10 more cycles.
- PRESCALE=4, load 3, drop `en` for 6 cycles after the first decrement → total time to `done` = 12+6 cycles; `count` frozen at 2 during the pause.
- Load 0 → DONE immediately, `done`=1 for 1 cycle, `busy`=0.
- Load 2 with a reload of 7 asserted on the cycle `count` would reach 0 → `count`=7, no `done`; `clear` mid-count → `count`=0, IDLE, no `done`.
- With `LATCH_DOWNCOUNTER_RELOAD_EN` defined, load 3 at PRESCALE=1 → `count` sequence 3,2,1,3,2,1… with `done` pulsing every 3 cycles.
